// File: rtl/vga_layer_arbiter.sv
// vga_layer_arbiter: per-pixel priority mux of NUM_LAYERS rectangles over a background colour.
// Define VGA_ARB_SHADOW_EN to double-buffer config writes and commit them at frame_start.
module vga_layer_arbiter #(
    parameter int NUM_LAYERS = 4,
    parameter int CW         = 11
) (
    input  logic          TD_CLK,
    input  logic          reset,
    input  logic [CW-1:0] x_cnt,
    input  logic [CW-1:0] y_cnt,
    input  logic          frame_start,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [2:0]    cfg_layer,
    input  logic [2:0]    cfg_field,
    input  logic [23:0]   cfg_data,
    output logic [7:0]    rgb_r,
    output logic [7:0]    rgb_g,
    output logic [7:0]    rgb_b,
    output logic          pix_hit,
    output logic [2:0]    hit_layer
);

    typedef logic [NUM_LAYERS-1:0][CW-1:0] coord_tbl_t;
    typedef logic [NUM_LAYERS-1:0][23:0]   colour_tbl_t;

    coord_tbl_t            x0_wr, x1_wr, y0_wr, y1_wr;
    colour_tbl_t           colour_wr;
    logic [NUM_LAYERS-1:0] en_wr;
    logic [23:0]           bg_wr;

    coord_tbl_t            x0_act, x1_act, y0_act, y1_act;
    colour_tbl_t           colour_act;
    logic [NUM_LAYERS-1:0] en_act;
    logic [23:0]           bg_act;

    logic wr_fire;
    logic layer_ok;

    assign wr_fire  = cfg_valid && cfg_ready;
    assign layer_ok = {29'd0, cfg_layer} < 32'(NUM_LAYERS);

    // Writes to a missing layer or to field 6 are handshaken but leave the table alone.
    always_ff @(posedge TD_CLK or negedge reset) begin
        if (!reset) begin
            x0_wr     <= '0;
            x1_wr     <= '0;
            y0_wr     <= '0;
            y1_wr     <= '0;
            colour_wr <= '0;
            en_wr     <= '0;
            bg_wr     <= '0;
        end else if (wr_fire) begin
            if (cfg_field == 3'd7) begin
                bg_wr <= cfg_data;
            end else if (layer_ok) begin
                for (int i = 0; i < NUM_LAYERS; i++) begin
                    if (cfg_layer == 3'(i)) begin
                        case (cfg_field)
                            3'd0:    x0_wr[i]     <= cfg_data[CW-1:0];
                            3'd1:    x1_wr[i]     <= cfg_data[CW-1:0];
                            3'd2:    y0_wr[i]     <= cfg_data[CW-1:0];
                            3'd3:    y1_wr[i]     <= cfg_data[CW-1:0];
                            3'd4:    colour_wr[i] <= cfg_data;
                            3'd5:    en_wr[i]     <= cfg_data[0];
                            default: ;
                        endcase
                    end
                end
            end
        end
    end

`ifdef VGA_ARB_SHADOW_EN
    typedef enum logic [1:0] {
        ACCEPT,
        PENDING,
        COMMIT
    } state_t;

    state_t state, state_next;

    always_ff @(posedge TD_CLK or negedge reset) begin
        if (!reset) begin
            state <= ACCEPT;
        end else begin
            state <= state_next;
        end
    end

    // cfg_ready is 1 in ACCEPT, so cfg_valid alone marks an accepted write there.
    always_comb begin
        state_next = state;
        cfg_ready  = 1'b1;
        case (state)
            ACCEPT:  if (cfg_valid) state_next = PENDING;
            PENDING: if (frame_start) state_next = COMMIT;
            COMMIT: begin
                cfg_ready  = 1'b0;
                state_next = ACCEPT;
            end
            default: state_next = ACCEPT;
        endcase
    end

    // The copy lands at the end of COMMIT so a write taken with the frame_start pulse is included.
    always_ff @(posedge TD_CLK or negedge reset) begin
        if (!reset) begin
            x0_act     <= '0;
            x1_act     <= '0;
            y0_act     <= '0;
            y1_act     <= '0;
            colour_act <= '0;
            en_act     <= '0;
            bg_act     <= '0;
        end else if (state == COMMIT) begin
            x0_act     <= x0_wr;
            x1_act     <= x1_wr;
            y0_act     <= y0_wr;
            y1_act     <= y1_wr;
            colour_act <= colour_wr;
            en_act     <= en_wr;
            bg_act     <= bg_wr;
        end
    end
`else
    logic unused_frame_start;

    assign unused_frame_start = frame_start;
    assign cfg_ready  = 1'b1;
    assign x0_act     = x0_wr;
    assign x1_act     = x1_wr;
    assign y0_act     = y0_wr;
    assign y1_act     = y1_wr;
    assign colour_act = colour_wr;
    assign en_act     = en_wr;
    assign bg_act     = bg_wr;
`endif

    logic [NUM_LAYERS-1:0] hit;
    logic [NUM_LAYERS-1:0] hit_q;

    always_comb begin
        hit = '0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            hit[i] = en_act[i]
                  && (x_cnt > x0_act[i]) && (x_cnt < x1_act[i])
                  && (y_cnt > y0_act[i]) && (y_cnt < y1_act[i]);
        end
    end

    always_ff @(posedge TD_CLK or negedge reset) begin
        if (!reset) begin
            hit_q <= '0;
        end else begin
            hit_q <= hit;
        end
    end

    logic        win_any;
    logic [2:0]  win_idx;
    logic [23:0] win_colour;

    // Scan from the highest index down so the lowest-index hit is the last one to overwrite.
    always_comb begin
        win_any    = 1'b0;
        win_idx    = 3'd0;
        win_colour = bg_act;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (hit_q[i]) begin
                win_any    = 1'b1;
                win_idx    = 3'(i);
                win_colour = colour_act[i];
            end
        end
    end

    logic [23:0] rgb_q;

    always_ff @(posedge TD_CLK or negedge reset) begin
        if (!reset) begin
            rgb_q     <= '0;
            pix_hit   <= 1'b0;
            hit_layer <= 3'd0;
        end else begin
            rgb_q     <= win_colour;
            pix_hit   <= win_any;
            hit_layer <= win_idx;
        end
    end

    assign rgb_r = rgb_q[7:0];
    assign rgb_g = rgb_q[15:8];
    assign rgb_b = rgb_q[23:16];

endmodule
